// File: rtl/usb_chan_pkg.sv
// Shared types and constants for the USB<->Pulpino channel sequencer.
// Latency: n/a (types, constants and pure byte-lane helpers only).
// Backpressure: n/a.
// Contents: TX/RX state encodings, word/byte geometry, byte-lane get/put helpers.
package usb_chan_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int IDX_W          = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_ERR  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_WAIT = 2'd1,
    RX_FULL = 2'd2,
    RX_ERR  = 2'd3
  } rx_state_e;

  // Byte lane idx of a word; lane 0 is bits [7:0].
  function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] w,
                                          input logic [IDX_W-1:0]  idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Word with byte lane idx replaced by b.
  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [IDX_W-1:0]  idx,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/usb_chan_watchdog.sv
// Per-direction ack watchdog: counts cycles spent waiting for a channel ack.
// Latency: expired is high in the cycle whose count would reach 2^W-1.
// Backpressure: none; clear dominates count_en.
// Ports: clk, reset_i (async, active-high), count_en (in WAIT), clear (ack/toggle/not
// waiting), expired (combinational pulse to the owning FSM).
module usb_chan_watchdog #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset_i,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
  // One below all-ones: the increment out of this value is the timeout.
  localparam logic [W-1:0] LAST_CNT = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count_en & ~clear & (cnt_q == LAST_CNT);

endmodule

// File: rtl/usb_channel_sequencer.sv
// Word<->byte sequencer between the Pulpino core and the USB byte channel (flicker handshakes).
// Latency: 2 cycles per byte against a 1-cycle channel; 8 cycles per word each direction.
// Backpressure: TX via tx_valid_i/tx_ready_o; RX word held in FULL until rx_ready_i.
// Ports: tx_word_i/tx_valid_i/tx_ready_o/tx_err_o (core TX), rx_req_i/rx_word_o/rx_valid_o/
// rx_ready_i/rx_err_o (core RX), err_clr_i, ch_wr_* and ch_rd_* (channel flicker pairs).
module usb_channel_sequencer
  import usb_chan_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] tx_word_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_err_o,
  input  logic        rx_req_i,
  output logic [31:0] rx_word_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_err_o,
  input  logic        err_clr_i,
  output logic [7:0]  ch_wr_data_o,
  output logic        ch_wr_flicker_o,
  input  logic        ch_wr_ack_i,
  input  logic [7:0]  ch_rd_data_i,
  output logic        ch_rd_flicker_o,
  input  logic        ch_rd_ack_i
);

  // ---------------- TX ----------------
  tx_state_e         tx_state_q, tx_state_d;
  logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
  logic [WORD_W-1:0] tx_word_q, tx_word_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_flk_q, wr_flk_d;
  logic              tx_err_q, tx_err_d;
  logic              tx_ack, tx_expired;

  // The channel has taken the current byte once its read flicker catches up.
  assign tx_ack = (ch_wr_ack_i == wr_flk_q);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_word_d  = tx_word_q;
    wr_data_d  = wr_data_q;
    wr_flk_d   = wr_flk_q;
    tx_err_d   = tx_err_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid_i) begin
          tx_word_d  = tx_word_i;
          tx_idx_d   = '0;
          wr_data_d  = tx_word_i[7:0];
          wr_flk_d   = ~wr_flk_q;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_ack) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_idx_d  = tx_idx_q + 2'd1;
            wr_data_d = get_byte(tx_word_q, tx_idx_q + 2'd1);
            wr_flk_d  = ~wr_flk_q;
          end
        end else if (tx_expired) begin
          tx_state_d = TX_ERR;
        end
      end
      // ERR keeps index and flicker untouched so the channel's byte count stays aligned.
      TX_ERR: begin
        if (err_clr_i) begin
          tx_state_d = TX_WAIT;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // A timeout in the same cycle as a clear must still leave the flag set.
    if (tx_expired) begin
      tx_err_d = 1'b1;
    end else if (err_clr_i) begin
      tx_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_word_q  <= '0;
      wr_data_q  <= '0;
      wr_flk_q   <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_word_q  <= tx_word_d;
      wr_data_q  <= wr_data_d;
      wr_flk_q   <= wr_flk_d;
      tx_err_q   <= tx_err_d;
    end
  end

  // Cleared whenever not waiting, so re-entering WAIT from ERR starts from zero.
  usb_chan_watchdog #(.W(TIMEOUT_W)) u_tx_wdog (
    .clk      (clk),
    .reset_i  (reset_i),
    .count_en (tx_state_q == TX_WAIT),
    .clear    ((tx_state_q != TX_WAIT) | tx_ack),
    .expired  (tx_expired)
  );

  assign tx_ready_o      = (tx_state_q == TX_IDLE);
  assign tx_err_o        = tx_err_q;
  assign ch_wr_data_o    = wr_data_q;
  assign ch_wr_flicker_o = wr_flk_q;

  // ---------------- RX ----------------
  rx_state_e         rx_state_q, rx_state_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic [WORD_W-1:0] rx_word_q, rx_word_d;
  logic              rd_flk_q, rd_flk_d;
  logic              rx_err_q, rx_err_d;
  logic              rx_ack, rx_expired;

  // The channel presents a fresh byte when its write flicker differs from ours.
  assign rx_ack = (ch_rd_ack_i != rd_flk_q);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_idx_d   = rx_idx_q;
    rx_word_d  = rx_word_q;
    rd_flk_d   = rd_flk_q;
    rx_err_d   = rx_err_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_req_i) begin
          rx_idx_d   = '0;
          rx_word_d  = put_byte(rx_word_q, '0, ch_rd_data_i);
          rd_flk_d   = ~rd_flk_q;
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_ack) begin
          if (rx_idx_q == LAST_IDX) begin
            rx_state_d = RX_FULL;
          end else begin
            rx_idx_d  = rx_idx_q + 2'd1;
            rx_word_d = put_byte(rx_word_q, rx_idx_q + 2'd1, ch_rd_data_i);
            rd_flk_d  = ~rd_flk_q;
          end
        end else if (rx_expired) begin
          rx_state_d = RX_ERR;
        end
      end
      RX_FULL: begin
        if (rx_ready_i) begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_ERR: begin
        if (err_clr_i) begin
          rx_state_d = RX_WAIT;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_expired) begin
      rx_err_d = 1'b1;
    end else if (err_clr_i) begin
      rx_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rx_state_q <= RX_IDLE;
      rx_idx_q   <= '0;
      rx_word_q  <= '0;
      rd_flk_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_idx_q   <= rx_idx_d;
      rx_word_q  <= rx_word_d;
      rd_flk_q   <= rd_flk_d;
      rx_err_q   <= rx_err_d;
    end
  end

  usb_chan_watchdog #(.W(TIMEOUT_W)) u_rx_wdog (
    .clk      (clk),
    .reset_i  (reset_i),
    .count_en (rx_state_q == RX_WAIT),
    .clear    ((rx_state_q != RX_WAIT) | rx_ack),
    .expired  (rx_expired)
  );

  assign rx_word_o       = rx_word_q;
  assign rx_valid_o      = (rx_state_q == RX_FULL);
  assign rx_err_o        = rx_err_q;
  assign ch_rd_flicker_o = rd_flk_q;

endmodule

// File: doc/usb_channel_sequencer.md
Name: usb_channel_sequencer

Overview:
- Pulpino-side controller for the USB<->Pulpino byte channel.
- Converts word-level requests from the Pulpino core into the channel's 4-byte flicker handshakes in both directions.
  - TX: core word -> four bytes pushed into the channel's Pulpino->USB register.
  - RX: four bytes pulled from the USB->Pulpino register -> one word.
- Sits between the core's peripheral logic and the channel. Both directions are independent, and each has a per-direction watchdog with a sticky error flag.

Parameters:
- TIMEOUT_W, 8: width of the per-byte ack watchdog. Timeout fires after 2^TIMEOUT_W-1 cycles in WAIT.

Ports:
- clk  in  1  single clock; all flops on posedge.
- reset_i  in  1  asynchronous, active-high reset. The channel shares this same reset.
- tx_word_i  in  32  word to send to USB.
- tx_valid_i  in  1  TX request.
- tx_ready_o  out  1  TX idle; a word is accepted when tx_valid_i and tx_ready_o are both high.
- tx_err_o  out  1  sticky TX timeout flag.
- rx_req_i  in  1  request one word from USB.
- rx_word_o  out  32  assembled RX word.
- rx_valid_o  out  1  rx_word_o valid; held until rx_ready_i.
- rx_ready_i  in  1  core consumes the RX word.
- rx_err_o  out  1  sticky RX timeout flag.
- err_clr_i  in  1  clears both error flags; resumes any errored direction.
- ch_wr_data_o  out  8  byte to channel; connects to pulpino_to_usb_data.
- ch_wr_flicker_o  out  1  connects to pulpino_write_flicker.
- ch_wr_ack_i  in  1  connects to usb_read_flicker.
- ch_rd_data_i  in  8  byte from channel; connects to usb_to_pulpino_data.
- ch_rd_flicker_o  out  1  connects to pulpino_read_flicker.
- ch_rd_ack_i  in  1  connects to usb_write_flicker.

Behaviour:
- Reset values:
  - States: IDLE. Byte indices: 0. Watchdogs: 0.
  - tx_ready_o=1, rx_valid_o=0, rx_word_o=0.
  - ch_wr_data_o=0, ch_wr_flicker_o=0, ch_rd_flicker_o=0, both err=0.
- Byte order: LSB first in both directions (byte0 = bits[7:0]).
- TX FSM (IDLE, WAIT, ERR):
  - TX idle condition: ch_wr_flicker_o == ch_wr_ack_i.
  - IDLE, on accept: latch word; idx=0; register ch_wr_data_o=byte0 and toggle ch_wr_flicker_o on the same edge; go to WAIT.
    - Data and flicker change together; data stays stable until the next toggle.
  - WAIT, ack (ch_wr_ack_i == ch_wr_flicker_o):
    - If idx==3: go to IDLE; tx_ready_o=1.
    - Else: idx+1; drive the next byte and toggle on the same edge; stay in WAIT.
  - Latency: 2 cycles per byte against the 1-cycle channel. tx_ready_o returns high 8 cycles after accept.
  - tx_ready_o is low in WAIT and ERR.
- RX FSM (IDLE, WAIT, FULL, ERR):
  - RX idle condition: ch_rd_flicker_o != ch_rd_ack_i.
  - IDLE, rx_req_i: capture ch_rd_data_i into byte0 of the shift register and toggle ch_rd_flicker_o on the same edge; go to WAIT.
  - WAIT, ack (ch_rd_ack_i != ch_rd_flicker_o):
    - If idx==3: go to FULL; rx_valid_o=1.
    - Else: idx+1; capture the next byte and toggle.
  - rx_req_i is ignored outside IDLE.
  - FULL: hold rx_word_o. When rx_ready_i is high: rx_valid_o=0 on the next edge and go to IDLE.
  - rx_req_i in the same cycle as the FULL->IDLE exit is ignored.
  - rx_valid_o rises 8 cycles after the request.
- Watchdog, per direction:
  - Counts while in WAIT; cleared on each ack and on every toggle.
  - Reaching 2^TIMEOUT_W-1 moves the FSM to ERR and sets err.
  - ERR does not toggle and does not touch the byte index, so alignment with the channel's byte counter is kept.
- err_clr_i:
  - Clears both err flags; each FSM in ERR returns to WAIT with its watchdog at 0.
  - No effect in other states.
  - If err_clr_i coincides with a timeout in the same cycle, the timeout wins.
- Simultaneous events: TX and RX may run concurrently; they share no state apart from err_clr_i.
- Reset mid-word: all state returns to reset values. The channel resets on the same reset_i, so byte alignment is restored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package usb_chan_pkg holds:
  - tx/rx state encodings;
  - BYTES_PER_WORD=4;
  - IDX_W=2;
  - LAST_IDX=2'd3.
- Sub-module usb_chan_watchdog, instantiated twice (TX and RX):
  - inputs: count_en, clear;
  - output: expired.

Test Plan:
- TX single word: tx_word_i=32'hDEADBEEF with valid, real channel attached.
  - Bytes EF,BE,AD,DE go out on successive toggles.
  - pulpino_to_usb_reg=32'hDEADBEEF.
  - tx_ready_o high 8 cycles after accept.
- RX single word: usb_to_pulpino_reg=32'h12345678, rx_req_i pulse.
  - rx_valid_o after 8 cycles with rx_word_o=32'h12345678.
  - Holds until rx_ready_i, then clears next cycle.
- Back-to-back concurrent: TX 32'h01020304 then 32'hA5A55A5A with valid held high; RX requested simultaneously.
  - Both words are correct; second TX accepted the cycle tx_ready_o rises.
  - RX unaffected.
- Timeout: channel ack forced constant after byte 1, TIMEOUT_W=4.
  - tx_err_o=1 after 15 cycles in WAIT; no further toggles.
  - err_clr_i, then release ack: transfer completes with the correct word.
- Reset mid-word: assert reset_i after 2 TX bytes.
  - All outputs at reset values.
  - Next word 32'hCAFEF00D arrives intact.
- Ignored request: rx_req_i while in FULL.
  - No extra toggle of ch_rd_flicker_o; rx_word_o unchanged.
